microwave_countdown_timer: RTL and testbench

MM:SS countdown timer for the microwave controller; the down-counting counterpart of the free-running up counters. Loads a cook time, decrements once per 1 Hz tick while running, and flags completion. Sits between the keypad/control FSM and the display/magnetron drivers.

---
 rtl/microwave_countdown_timer_pkg.sv | 19 +
 rtl/microwave_countdown_timer_bcd_down_digit.sv | 39 +++
 rtl/microwave_countdown_timer.sv | 130 +++++++++++++
 tb/tb_microwave_countdown_timer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/microwave_countdown_timer_pkg.sv
// Shared types and constants for the microwave MM:SS countdown timer.
package microwave_countdown_timer_pkg;

  localparam int unsigned MinWidth     = 4;
  localparam int unsigned SecTensWidth = 3;
  localparam int unsigned SecOnesWidth = 4;

  localparam int unsigned SecTensMax = 5;
  localparam int unsigned DigitMax   = 9;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoaded  = 3'd1,
    StRunning = 3'd2,
    StPaused  = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/microwave_countdown_timer_bcd_down_digit.sv
// One loadable down-counting digit; wraps 0 -> MODULUS-1 and flags a borrow on that step.
module microwave_countdown_timer_bcd_down_digit #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned Width   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] value,
  output logic             is_zero,
  output logic             borrow_out
);

  logic [Width-1:0] value_q, value_d;

  assign is_zero    = (value_q == '0);
  assign borrow_out = dec && is_zero;
  assign value      = value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec) begin
      value_d = is_zero ? Width'(MODULUS - 1) : value_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/microwave_countdown_timer.sv
// MM:SS countdown timer: load/start/pause/cancel control with a 1 Hz BCD borrow chain.
module microwave_countdown_timer
  import microwave_countdown_timer_pkg::*;
#(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    load,
  input  logic [MinWidth-1:0]     min_in,
  input  logic [SecTensWidth-1:0] sec_tens_in,
  input  logic [SecOnesWidth-1:0] sec_ones_in,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  output logic [MinWidth-1:0]     min_bcd,
  output logic [SecTensWidth-1:0] sec_tens,
  output logic [SecOnesWidth-1:0] sec_ones,
  output logic                    running,
  output logic                    done
);

  state_e state_q, state_d;

  logic [MinWidth-1:0]     min_clamp, min_ld;
  logic [SecTensWidth-1:0] tens_clamp, tens_ld;
  logic [SecOnesWidth-1:0] ones_clamp, ones_ld;
  logic                    digit_load, dec_en;
  logic                    ones_zero, tens_zero, min_zero;
  logic                    ones_borrow, tens_borrow, unused_min_borrow;
  logic                    value_nonzero, value_is_one, clamp_nonzero;

  assign min_clamp  = (min_in > MinWidth'(MAX_MIN)) ? MinWidth'(MAX_MIN) : min_in;
  assign tens_clamp = (sec_tens_in > SecTensWidth'(SecTensMax)) ?
                      SecTensWidth'(SecTensMax) : sec_tens_in;
  assign ones_clamp = (sec_ones_in > SecOnesWidth'(DigitMax)) ?
                      SecOnesWidth'(DigitMax) : sec_ones_in;

  assign clamp_nonzero = (min_clamp != '0) || (tens_clamp != '0) || (ones_clamp != '0);
  assign value_nonzero = !(ones_zero && tens_zero && min_zero);
  assign value_is_one  = (sec_ones == SecOnesWidth'(1)) && tens_zero && min_zero;

  // Strict priority: the highest asserted input owns the cycle even if it is ignored.
  always_comb begin
    state_d    = state_q;
    digit_load = 1'b0;
    dec_en     = 1'b0;
    min_ld     = min_clamp;
    tens_ld    = tens_clamp;
    ones_ld    = ones_clamp;
    if (cancel) begin
      state_d    = StIdle;
      digit_load = 1'b1;
      min_ld     = '0;
      tens_ld    = '0;
      ones_ld    = '0;
    end else if (load) begin
      if (state_q != StRunning) begin
        digit_load = 1'b1;
        state_d    = clamp_nonzero ? StLoaded : StIdle;
      end
    end else if (pause) begin
      if (state_q == StRunning) state_d = StPaused;
    end else if (start) begin
      if ((state_q == StLoaded || state_q == StPaused) && value_nonzero) begin
        state_d = StRunning;
      end
    end else if (tick) begin
      if (state_q == StRunning && value_nonzero) begin
        dec_en = 1'b1;
        if (value_is_one) state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign running = (state_q == StRunning);
  assign done    = (state_q == StDone);

  microwave_countdown_timer_bcd_down_digit #(
    .MODULUS(DigitMax + 1),
    .Width  (SecOnesWidth)
  ) u_ones (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (ones_ld),
    .dec       (dec_en),
    .value     (sec_ones),
    .is_zero   (ones_zero),
    .borrow_out(ones_borrow)
  );

  microwave_countdown_timer_bcd_down_digit #(
    .MODULUS(SecTensMax + 1),
    .Width  (SecTensWidth)
  ) u_tens (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (tens_ld),
    .dec       (ones_borrow),
    .value     (sec_tens),
    .is_zero   (tens_zero),
    .borrow_out(tens_borrow)
  );

  microwave_countdown_timer_bcd_down_digit #(
    .MODULUS(MAX_MIN + 1),
    .Width  (MinWidth)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .load      (digit_load),
    .load_val  (min_ld),
    .dec       (tens_borrow),
    .value     (min_bcd),
    .is_zero   (min_zero),
    .borrow_out(unused_min_borrow)
  );

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Directed bench for microwave_countdown_timer with hand-computed expected MM:SS values.
module tb_microwave_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [3:0] min_in = '0;
  logic [2:0] sec_tens_in = '0;
  logic [3:0] sec_ones_in = '0;
  logic [3:0] min_bcd;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running, done;

  int total = 0;
  int bad   = 0;

  microwave_countdown_timer #(
    .MAX_MIN(9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .min_in     (min_in),
    .sec_tens_in(sec_tens_in),
    .sec_ones_in(sec_ones_in),
    .start      (start),
    .pause      (pause),
    .cancel     (cancel),
    .min_bcd    (min_bcd),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] em, input logic [2:0] et,
                       input logic [3:0] eo, input logic er, input logic ed);
    logic [12:0] obs, exp;
    obs = {min_bcd, sec_tens, sec_ones, running, done};
    exp = {em, et, eo, er, ed};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d%0d:%0d run=%b done=%b, required %0d%0d:%0d run=%b done=%b",
             tag, obs[12:9], obs[8:6], obs[5:2], obs[1], obs[0],
             exp[12:9], exp[8:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic do_load(input logic [3:0] m, input logic [2:0] t, input logic [3:0] o);
    load = 1'b1; min_in = m; sec_tens_in = t; sec_ones_in = o;
    cycle();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1; cycle(); cancel = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    tick = 1'b0;
  endtask

  initial begin
    #1;
    check("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle();

    // 01:00 full minute down to done, tick held high across consecutive cycles
    do_load(1, 0, 0);
    check("load_0100", 1, 0, 0, 0, 0);
    pulse_start();
    check("start_0100", 1, 0, 0, 1, 0);
    ticks(1);
    check("min_borrow_0059", 0, 5, 9, 1, 0);
    ticks(9);
    check("tens_borrow_0050", 0, 5, 0, 1, 0);
    ticks(49);
    check("at_0001", 0, 0, 1, 1, 0);
    ticks(1);
    check("done_0000", 0, 0, 0, 0, 1);
    ticks(3);
    check("done_holds", 0, 0, 0, 0, 1);
    pulse_start();
    check("start_in_done", 0, 0, 0, 0, 1);
    pulse_cancel();
    check("cancel_done", 0, 0, 0, 0, 0);

    // pause / resume
    do_load(0, 1, 0);
    pulse_start();
    ticks(1);
    check("run_0009", 0, 0, 9, 1, 0);
    pause = 1'b1; tick = 1'b1; cycle(); pause = 1'b0; tick = 1'b0;
    check("pause_tick_same", 0, 0, 9, 0, 0);
    ticks(3);
    check("paused_holds", 0, 0, 9, 0, 0);
    pulse_start();
    check("resume", 0, 0, 9, 1, 0);
    ticks(1);
    check("resume_0008", 0, 0, 8, 1, 0);
    pulse_cancel();

    // clamping
    do_load(12, 7, 11);
    check("clamp_0959", 9, 5, 9, 0, 0);
    pulse_start();
    check("clamp_start", 9, 5, 9, 1, 0);
    pulse_cancel();

    // zero load stays idle; load while running ignored
    do_load(0, 0, 0);
    pulse_start();
    check("zero_load_start", 0, 0, 0, 0, 0);
    do_load(0, 0, 5);
    pulse_start();
    do_load(2, 3, 0);
    check("load_in_running", 0, 0, 5, 1, 0);
    ticks(1);
    check("continue_0004", 0, 0, 4, 1, 0);
    pulse_cancel();

    // cancel beats tick; load beats start; start beats tick
    do_load(5, 4, 2);
    pulse_start();
    check("run_0542", 5, 4, 2, 1, 0);
    cancel = 1'b1; tick = 1'b1; cycle(); cancel = 1'b0; tick = 1'b0;
    check("cancel_tick", 0, 0, 0, 0, 0);
    load = 1'b1; start = 1'b1; min_in = 1; sec_tens_in = 2; sec_ones_in = 3;
    cycle();
    load = 1'b0; start = 1'b0;
    check("load_start_same", 1, 2, 3, 0, 0);
    ticks(2);
    check("loaded_tick_ign", 1, 2, 3, 0, 0);
    start = 1'b1; tick = 1'b1; cycle(); start = 1'b0; tick = 1'b0;
    check("start_tick_same", 1, 2, 3, 1, 0);
    pulse_cancel();

    // async reset mid-cycle while running
    do_load(3, 1, 5);
    pulse_start();
    check("run_0315", 3, 1, 5, 1, 0);
    #3 rst = 1'b1;
    #1 check("async_rst", 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    ticks(3);
    check("post_rst_ticks", 0, 0, 0, 0, 0);
    pulse_start();
    check("post_rst_start", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
